bsg_abs_accum: RTL and testbench
================================

// Module: bsg_abs_accum
// PURPOSE
//  Streaming L1-norm stage downstream of bsg_abs: accepts signed samples over valid/ready,
//  takes |x| via an internal bsg_abs, accumulates a programmable window of samples, then
//  presents the window sum over valid/yumi. Sits between a sample source and a consumer
//  (e.g. an energy/threshold detector).
// PARAMETERS
//  width_p        16                    sample width; two's-complement signed
//  count_width_p  8                     window-length field width; window = len_i+1 samples
//  sum_width_p    width_p+count_width_p sum width; fixed, not overridable by instantiator
// PORTS
//  clk_i     in   1              clock
//  reset_i   in   1              synchronous reset, active high
//  len_i     in   count_width_p  window length minus 1; sampled with first sample of window
//  v_i       in   1              sample valid
//  data_i    in   width_p        signed sample
//  ready_o   out  1              block can accept a sample this cycle
//  v_o       out  1              window sum valid
//  sum_o     out  sum_width_p    unsigned sum of |data_i| over window
//  yumi_i    in   1              consumer takes sum_o; legal only when v_o=1
//  max_o     out  width_p        (BSG_ABS_ACCUM_PEAK_EN only) largest |data_i| in window
// BEHAVIOUR
//  - One clock (clk_i); reset_i synchronous, active high. While reset_i=1: ready_o=0, v_o=0.
//    State after reset: eAccum, sum=0, cnt=0, len_r=0, max=0.
//  - |x| is treated as unsigned width_p bits: -2^(width_p-1) -> 2^(width_p-1) (0x8000 = 32768).
//  - Sum never overflows: max 2^count_width_p * 2^(width_p-1) < 2^sum_width_p.
//  - FSM: eAccum, eDone.
//    eAccum: ready_o=1, v_o=0. Accept when v_i&ready_o. If cnt==0, len_r<=len_i and
//      sum<=|x| (start fresh); else sum<=sum+|x|. Window complete when the accepted sample's
//      index equals the effective length (len_i if cnt==0, else len_r). On completion go to
//      eDone, cnt<=0; otherwise cnt<=cnt+1.
//    eDone: ready_o=0, v_o=1, sum_o stable. On yumi_i: clear sum, go to eAccum next cycle.
//  - Latency: v_o rises the cycle after the last sample is accepted. One-bubble turnaround:
//    a sample cannot be accepted in the yumi_i cycle.
//  - len_i changes mid-window are ignored until the next window starts.
//  - v_i while ready_o=0: not accepted, no state change. yumi_i while v_o=0: ignored
//    (assertion error in simulation).
//  - reset_i mid-window or while in eDone: the partial or unconsumed sum is discarded.
//  - sum_o is driven from the register at all times; it is meaningful only when v_o=1.
// CONFIGURATION
//  BSG_ABS_ACCUM_PEAK_EN defined: port max_o exists; peak register is loaded on the first
//    sample and updated to the max of itself and |x| on each later accept. It clears on
//    yumi_i and reset, and is valid together with sum_o.
//  Undefined: no max_o port, no peak logic; all else identical.
// STRUCTURE
//  - Package bsg_abs_accum_pkg: state enum typedef (eAccum, eDone).
//  - Sub-module: one bsg_abs instance (width_p) for |data_i|. Datapath and FSM live in this
//    module; there is no other hierarchy.
// TESTING
//  1 len_i=3, samples 5,-3,-32768,7 -> v_o 1 cycle after 4th accept, sum_o=32783.
//  2 Hold yumi_i=0 for 10 cycles with v_i=1 and data_i changing -> ready_o=0, sum_o
//    unchanged, no sample consumed.
//  3 len_i=0, samples -1,0,100 -> three windows with sums 1,0,100; a bubble follows each yumi_i.
//  4 len_i=255, 256 samples of -32768 -> sum_o=8388608 (2^23), no wrap.
//  5 len_i=4; after 2 accepts assert reset_i 1 cycle; then len_i=1, samples 2,3 -> sum_o=5.
//  6 PEAK_EN, len_i=2, samples 2,-9,4 -> sum_o=15, max_o=9; next window 1,1,1 -> max_o=1.

Source files
------------

// File: rtl/bsg_abs_accum_pkg.sv
// Shared types for the bsg_abs_accum streaming L1-norm stage.
package bsg_abs_accum_pkg;

  typedef enum logic {
    eAccum = 1'b0,
    eDone  = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_abs_accum_if.sv
// Sample-in / sum-out handshake bundle for bsg_abs_accum.
// max_o exists only when BSG_ABS_ACCUM_PEAK_EN is defined.
interface bsg_abs_accum_if #(
  parameter int width_p       = 16,
  parameter int count_width_p = 8
);

  localparam int sum_width_p = width_p + count_width_p;

  logic [count_width_p-1:0] len_i;
  logic                     v_i;
  logic [width_p-1:0]       data_i;
  logic                     ready_o;
  logic                     v_o;
  logic [sum_width_p-1:0]   sum_o;
  logic                     yumi_i;
`ifdef BSG_ABS_ACCUM_PEAK_EN
  logic [width_p-1:0]       max_o;
`endif

  // master = sample source plus sum consumer; slave = the accumulator itself
`ifdef BSG_ABS_ACCUM_PEAK_EN
  modport master (output len_i, v_i, data_i, yumi_i,
                  input  ready_o, v_o, sum_o, max_o);
  modport slave  (input  len_i, v_i, data_i, yumi_i,
                  output ready_o, v_o, sum_o, max_o);
`else
  modport master (output len_i, v_i, data_i, yumi_i,
                  input  ready_o, v_o, sum_o);
  modport slave  (input  len_i, v_i, data_i, yumi_i,
                  output ready_o, v_o, sum_o);
`endif

endinterface

// File: rtl/bsg_abs.sv
// Two's-complement magnitude; the most negative input maps to 2^(width_p-1)
// because the result is read as unsigned.
module bsg_abs #(
  parameter int width_p = 16
) (
  input  logic [width_p-1:0] a_i,
  output logic [width_p-1:0] o
);

  assign o = a_i[width_p-1] ? ('0 - a_i) : a_i;

endmodule

// File: rtl/bsg_abs_accum.sv
// Accumulates |x| over a window of len_i+1 samples and presents the sum over valid/yumi.
// Optional peak tracking (max_o) is enabled by defining BSG_ABS_ACCUM_PEAK_EN.
module bsg_abs_accum
  import bsg_abs_accum_pkg::*;
#(
  parameter int width_p       = 16,
  parameter int count_width_p = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  bsg_abs_accum_if.slave  io
);

  localparam int sum_width_p = width_p + count_width_p;

  state_e                   state_r;
  logic [sum_width_p-1:0]   sum_r;
  logic [count_width_p-1:0] cnt_r;
  logic [count_width_p-1:0] len_r;

  logic [width_p-1:0]       abs_x;
  logic [sum_width_p-1:0]   abs_ext;
  logic                     accept;
  logic                     first;
  logic [count_width_p-1:0] eff_len;
  logic                     last;

  bsg_abs #(.width_p(width_p)) abs_inst (
    .a_i (io.data_i),
    .o   (abs_x)
  );

  assign abs_ext = {{count_width_p{1'b0}}, abs_x};
  assign accept  = io.v_i & io.ready_o;
  // len_i is only honoured on the first sample; later changes wait for the next window
  assign first   = (cnt_r == '0);
  assign eff_len = first ? io.len_i : len_r;
  assign last    = (cnt_r == eff_len);

  // Handshake outputs are forced low during reset so the state register's
  // pre-reset contents never leak out.
  assign io.ready_o = ~reset_i & (state_r == eAccum);
  assign io.v_o     = ~reset_i & (state_r == eDone);
  assign io.sum_o   = sum_r;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eAccum;
      sum_r   <= '0;
      cnt_r   <= '0;
      len_r   <= '0;
    end else begin
      case (state_r)
        eAccum: begin
          if (accept) begin
            if (first) begin
              len_r <= io.len_i;
              sum_r <= abs_ext;
            end else begin
              sum_r <= sum_r + abs_ext;
            end
            if (last) begin
              state_r <= eDone;
              cnt_r   <= '0;
            end else begin
              cnt_r   <= cnt_r + 1'b1;
            end
          end
        end
        eDone: begin
          if (io.yumi_i) begin
            sum_r   <= '0;
            state_r <= eAccum;
          end
        end
        default: state_r <= eAccum;
      endcase
    end
  end

`ifdef BSG_ABS_ACCUM_PEAK_EN
  logic [width_p-1:0] max_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      max_r <= '0;
    end else if (accept) begin
      if (first || (abs_x > max_r)) max_r <= abs_x;
    end else if ((state_r == eDone) && io.yumi_i) begin
      max_r <= '0;
    end
  end

  assign io.max_o = max_r;
`endif

  // A consumer must never take a sum that is not being offered.
  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) io.yumi_i |-> io.v_o
  );

endmodule

// File: tb/tb_bsg_abs_accum.sv
// Self-checking bench for bsg_abs_accum: directed windows plus randomized traffic
// compared every cycle against a window-list model. Honours BSG_ABS_ACCUM_PEAK_EN.
module tb_bsg_abs_accum;

  localparam int width_p       = 16;
  localparam int count_width_p = 8;

  logic clk;
  logic reset;

  int checks;
  int errors;

  bsg_abs_accum_if #(.width_p(width_p), .count_width_p(count_width_p)) io ();

  bsg_abs_accum #(.width_p(width_p), .count_width_p(count_width_p)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int abs_of(input logic [width_p-1:0] d);
    int x;
    x = $signed(d);
    return (x < 0) ? -x : x;
  endfunction

  // Model: the current window is the list of |x| values accepted so far.
  bit m_started;
  bit m_done;
  int m_len;
  int m_q[$];

  function automatic longint q_sum();
    longint s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  function automatic int q_max();
    int m = 0;
    foreach (m_q[i]) if (m_q[i] > m) m = m_q[i];
    return m;
  endfunction

  initial begin
    m_started = 0;
    m_done    = 0;
    m_len     = 0;
    forever begin
      @(negedge clk);
      if (m_started) begin
        check("ready_o", io.ready_o, (!reset && !m_done) ? 1 : 0);
        check("v_o",     io.v_o,     (!reset &&  m_done) ? 1 : 0);
        if (!reset && m_done) begin
          check("sum_o", io.sum_o, q_sum());
`ifdef BSG_ABS_ACCUM_PEAK_EN
          check("max_o", io.max_o, q_max());
`endif
        end
      end
      @(posedge clk);
      if (reset) begin
        m_started = 1;
        m_done    = 0;
        m_q.delete();
      end else if (m_started) begin
        if (!m_done && io.v_i) begin
          if (m_q.size() == 0) m_len = int'(io.len_i);
          m_q.push_back(abs_of(io.data_i));
          if (m_q.size() == m_len + 1) m_done = 1;
        end else if (m_done && io.yumi_i) begin
          m_done = 0;
          m_q.delete();
        end
      end
    end
  end

  // Present one sample until it is accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input int len, input int data);
    bit r;
    int n;
    n = 0;
    io.v_i    = 1'b1;
    io.len_i  = len[count_width_p-1:0];
    io.data_i = data[width_p-1:0];
    do begin
      @(negedge clk);
      r = io.ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    if (!r) check("send_timeout", 0, 1);
    io.v_i = 1'b0;
  endtask

  task automatic take();
    int n;
    n = 0;
    @(negedge clk);
    while (!io.v_o && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!io.v_o) check("take_timeout", 0, 1);
    else begin
      io.yumi_i = 1'b1;
      @(posedge clk);
      #1;
      io.yumi_i = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int rand_sample();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return $signed(16'($urandom));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    io.v_i    = 1'b0;
    io.yumi_i = 1'b0;
    io.len_i  = '0;
    io.data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("reset_ready", io.ready_o, 1);
    check("reset_v",     io.v_o,     0);
    check("reset_sum",   io.sum_o,   0);
    @(posedge clk);
    #1;

    // Window of four mixed-sign samples including the most negative value.
    send(3, 5); send(3, -3); send(3, -32768); send(3, 7);
    @(negedge clk);
    check("t1_latency_v", io.v_o, 1);
    check("t1_sum", io.sum_o, 32783);
    @(posedge clk);
    #1;
    take();

    // Sum held while the consumer stalls; offered samples must not be consumed.
    send(1, 10); send(1, -20);
    for (int i = 0; i < 10; i++) begin
      io.v_i    = 1'b1;
      io.data_i = 16'($urandom);
      @(negedge clk);
      check("t2_ready_held", io.ready_o, 0);
      check("t2_sum_held",   io.sum_o,   30);
      @(posedge clk);
      #1;
    end
    io.v_i = 1'b0;
    take();
    send(0, 4);
    @(negedge clk);
    check("t2_no_consume_sum", io.sum_o, 4);
    @(posedge clk);
    #1;
    take();

    // Single-sample windows with a bubble after each yumi.
    send(0, -1);
    @(negedge clk); check("t3_sum_a", io.sum_o, 1);
    @(posedge clk); #1; take();
    @(negedge clk); check("t3_bubble_clear", io.ready_o, 1);
    @(posedge clk); #1;
    send(0, 0);
    @(negedge clk); check("t3_sum_b", io.sum_o, 0);
    @(posedge clk); #1; take();
    send(0, 100);
    @(negedge clk); check("t3_sum_c", io.sum_o, 100);
    @(posedge clk); #1; take();

    // Longest window of largest magnitudes.
    for (int i = 0; i < 256; i++) send(255, -32768);
    @(negedge clk);
    check("t4_sum_full", io.sum_o, 8388608);
    @(posedge clk);
    #1;
    take();

    // Reset mid-window discards the partial sum.
    send(4, 1); send(4, 1);
    pulse_reset();
    send(1, 2); send(1, 3);
    @(negedge clk);
    check("t5_v", io.v_o, 1);
    check("t5_sum", io.sum_o, 5);
    @(posedge clk);
    #1;
    take();

`ifdef BSG_ABS_ACCUM_PEAK_EN
    send(2, 2); send(2, -9); send(2, 4);
    @(negedge clk);
    check("t6_sum", io.sum_o, 15);
    check("t6_max", io.max_o, 9);
    @(posedge clk); #1; take();
    send(2, 1); send(2, 1); send(2, 1);
    @(negedge clk);
    check("t6_max_next", io.max_o, 1);
    @(posedge clk); #1; take();
`endif

    // Randomized windows: gaps, mid-window len changes, stalls with v_i toggling, resets.
    for (int w = 0; w < 40; w++) begin
      len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 9);
      for (int i = 0; i <= len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          io.data_i = 16'($urandom);
          @(posedge clk);
          #1;
        end
        send((i == 0) ? len : $urandom_range(0, 255), rand_sample());
      end
      repeat ($urandom_range(0, 3)) begin
        io.v_i    = 1'($urandom);
        io.data_i = 16'($urandom);
        @(posedge clk);
        #1;
      end
      io.v_i = 1'b0;
      if ($urandom_range(0, 9) == 0) pulse_reset();
      else take();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
